// File: rtl/pipe_control.sv
// pipe_control: ID-stage decode, branch/jump redirect, hazard stalls, multi-cycle M-op hold and ID/EX control register.
module pipe_control #(
  parameter bit MULDIV_EN  = 1'b1,
  parameter int MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] if_id_inst,
  input  logic        br_eq,
  output logic        stall,
  output logic        if_flush,
  output logic [1:0]  pc_src,
  output logic [2:0]  id_imm_sel,
  output logic        ex_valid,
  output logic        ex_alu_src,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_mem_to_reg,
  output logic        ex_muldiv,
  output logic [1:0]  ex_alu_op,
  output logic [4:0]  ex_rd,
  output logic        ex_busy,
  output logic        illegal_inst
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_LD = 7'b0000011, OP_IMM = 7'b0010011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
  logic [6:0] op, f7;
  logic [2:0] f3, imm;
  logic [4:0] rd, rs1, rs2, mem_rd;
  logic [3:0] cnt;
  logic [1:0] alu_op;
  logic legal, is_br, is_jal, is_jalr, alu_src, mem_read, mem_write, reg_write, mem_to_reg, muldiv, u1, u2;
  logic br, jalr, use1, use2, hit_ex, hit_mem, load_use, br_haz, busy, adv, go, taken, mem_load;
  assign op  = if_id_inst[6:0];
  assign rd  = if_id_inst[11:7];
  assign f3  = if_id_inst[14:12];
  assign rs1 = if_id_inst[19:15];
  assign rs2 = if_id_inst[24:20];
  assign f7  = if_id_inst[31:25];
  always_comb begin
    legal = 1'b0; is_br = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    alu_src = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
    muldiv = 1'b0; alu_op = 2'b00; imm = 3'b000; u1 = 1'b0; u2 = 1'b0;
    case (op)
      OP_R:    begin legal = (f7 != 7'b0000001) || MULDIV_EN; muldiv = f7 == 7'b0000001; alu_op = 2'b10; reg_write = 1'b1; imm = 3'b001; u1 = 1'b1; u2 = 1'b1; end
      OP_LD:   begin legal = 1'b1; alu_src = 1'b1; mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1; imm = 3'b010; u1 = 1'b1; end
      OP_IMM:  begin legal = 1'b1; alu_op = 2'b11; alu_src = 1'b1; reg_write = 1'b1; imm = 3'b010; u1 = 1'b1; end
      OP_ST:   begin legal = 1'b1; alu_src = 1'b1; mem_write = 1'b1; imm = 3'b011; u1 = 1'b1; u2 = 1'b1; end
      OP_BR:   begin legal = f3[2:1] == 2'b00; is_br = 1'b1; alu_op = 2'b01; imm = 3'b100; u1 = 1'b1; u2 = 1'b1; end
      OP_JAL:  begin legal = 1'b1; is_jal = 1'b1; reg_write = 1'b1; imm = 3'b101; end
      OP_JALR: begin legal = 1'b1; is_jalr = 1'b1; reg_write = 1'b1; imm = 3'b010; u1 = 1'b1; end
      OP_LUI:  begin legal = 1'b1; alu_src = 1'b1; reg_write = 1'b1; imm = 3'b110; end
      default: legal = 1'b0;
    endcase
  end
  assign id_imm_sel = legal ? imm : 3'b000;
  assign use1 = u1 & legal;
  assign use2 = u2 & legal;
  assign br   = is_br & legal;
  assign jalr = is_jalr & legal;
  assign hit_ex  = (ex_rd != 5'd0) && ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));
  assign hit_mem = (mem_rd != 5'd0) && ((use1 && rs1 == mem_rd) || (use2 && rs2 == mem_rd));
  assign load_use = ex_valid & ex_mem_read & hit_ex;
  // branch/JALR compare in ID, so results still in EX or a load in MEM are not yet forwardable
  assign br_haz = (br | jalr) & ((ex_valid & ex_reg_write & hit_ex) | (mem_load & hit_mem));
  assign busy    = cnt != 4'd0;
  assign ex_busy = busy;
  assign stall   = busy | (id_valid & (load_use | br_haz));
  assign adv     = id_valid & ~stall;
  assign go      = adv & legal;
  assign taken   = br & (br_eq ^ f3[0]);
  assign pc_src   = !adv ? 2'b00 : jalr ? 2'b10 : (taken | (is_jal & legal)) ? 2'b01 : 2'b00;
  assign if_flush = |pc_src;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_muldiv} <= '0;
      ex_alu_op <= 2'b00;
      ex_rd <= 5'd0;
      illegal_inst <= 1'b0;
      cnt <= 4'd0;
      mem_load <= 1'b0;
      mem_rd <= 5'd0;
    end else begin
      mem_load <= ex_valid & ex_mem_read;
      mem_rd <= ex_rd;
      illegal_inst <= adv & ~legal;
      if (busy) cnt <= cnt - 4'd1;
      else begin
        ex_valid <= go;
        ex_alu_src <= go & alu_src;
        ex_mem_read <= go & mem_read;
        ex_mem_write <= go & mem_write;
        ex_reg_write <= go & reg_write;
        ex_mem_to_reg <= go & mem_to_reg;
        ex_muldiv <= go & muldiv;
        ex_alu_op <= go ? alu_op : 2'b00;
        ex_rd <= (go & reg_write) ? rd : 5'd0;
        cnt <= (go & muldiv) ? 4'(MULDIV_LAT - 1) : 4'd0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: randomized scoreboard bench for pipe_control against an instruction-level pipeline model.
module tb_pipe_control;
  localparam int LAT = 4;
  localparam int K_R = 0, K_M = 1, K_LD = 2, K_OPI = 3, K_ST = 4, K_BR = 5, K_BADBR = 6, K_JAL = 7, K_JALR = 8, K_LUI = 9, K_BAD = 10;
  typedef struct { int k; logic [4:0] rd, rs1, rs2; logic f; } ins_t;
  logic clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, br_eq = 1'b0;
  logic [31:0] inst = 32'h0;
  logic stall, if_flush, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_muldiv, ex_busy, illegal_inst;
  logic [1:0] pc_src, ex_alu_op;
  logic [2:0] id_imm_sel;
  logic [4:0] ex_rd;
  logic u_stall, u_if_flush, u_ex_valid, u_ex_alu_src, u_ex_mem_read, u_ex_mem_write, u_ex_reg_write, u_ex_mem_to_reg, u_ex_muldiv, u_ex_busy, u_illegal;
  logic [1:0] u_pc_src, u_ex_alu_op;
  logic [2:0] u_id_imm_sel;
  logic [4:0] u_ex_rd;
  int checks = 0, errors = 0;
  logic [14:0] sb[$];
  ins_t ex_i;
  bit ex_v = 1'b0, mem_ld = 1'b0, prev_busy = 1'b0;
  logic [4:0] mem_rd = 5'd0;
  int busy_left = 0;

  pipe_control #(.MULDIV_EN(1'b1), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .if_id_inst(inst), .br_eq(br_eq),
    .stall(stall), .if_flush(if_flush), .pc_src(pc_src), .id_imm_sel(id_imm_sel),
    .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_muldiv(ex_muldiv), .ex_alu_op(ex_alu_op),
    .ex_rd(ex_rd), .ex_busy(ex_busy), .illegal_inst(illegal_inst));
  pipe_control #(.MULDIV_EN(1'b0), .MULDIV_LAT(LAT)) dut_nom (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .if_id_inst(inst), .br_eq(br_eq),
    .stall(u_stall), .if_flush(u_if_flush), .pc_src(u_pc_src), .id_imm_sel(u_id_imm_sel),
    .ex_valid(u_ex_valid), .ex_alu_src(u_ex_alu_src), .ex_mem_read(u_ex_mem_read), .ex_mem_write(u_ex_mem_write),
    .ex_reg_write(u_ex_reg_write), .ex_mem_to_reg(u_ex_mem_to_reg), .ex_muldiv(u_ex_muldiv), .ex_alu_op(u_ex_alu_op),
    .ex_rd(u_ex_rd), .ex_busy(u_ex_busy), .illegal_inst(u_illegal));

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input int k, input int rd, input int rs1, input int rs2, input bit f);
    ins_t i;
    i.k = k; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.f = f;
    return i;
  endfunction

  function automatic logic [31:0] enc(input ins_t i);
    case (i.k)
      K_R:     return {7'b0000000, i.rs2, i.rs1, 3'b000, i.rd, 7'b0110011};
      K_M:     return {7'b0000001, i.rs2, i.rs1, 3'b000, i.rd, 7'b0110011};
      K_LD:    return {12'h000, i.rs1, 3'b010, i.rd, 7'b0000011};
      K_OPI:   return {12'h005, i.rs1, 3'b000, i.rd, 7'b0010011};
      K_ST:    return {7'h00, i.rs2, i.rs1, 3'b010, i.rd, 7'b0100011};
      K_BR:    return {7'h00, i.rs2, i.rs1, 2'b00, i.f, i.rd, 7'b1100011};
      K_BADBR: return {7'h00, i.rs2, i.rs1, 2'b10, i.f, i.rd, 7'b1100011};
      K_JAL:   return {20'h00010, i.rd, 7'b1101111};
      K_JALR:  return {12'h000, i.rs1, 3'b000, i.rd, 7'b1100111};
      K_LUI:   return {20'h12345, i.rd, 7'b0110111};
      default: return {25'h0, 7'b0001111};
    endcase
  endfunction

  function automatic bit legal(input int k); return k != K_BADBR && k != K_BAD; endfunction
  function automatic bit writes(input int k); return k inside {K_R, K_M, K_LD, K_OPI, K_JAL, K_JALR, K_LUI}; endfunction
  function automatic bit reads(input ins_t i, input logic [4:0] r);
    bit a, b;
    a = legal(i.k) && !(i.k inside {K_JAL, K_LUI}) && i.rs1 == r;
    b = (i.k inside {K_R, K_M, K_ST, K_BR}) && i.rs2 == r;
    return r != 5'd0 && (a || b);
  endfunction
  function automatic int imm_of(input int k);
    case (k)
      K_R, K_M: return 1;
      K_LD, K_OPI, K_JALR: return 2;
      K_ST: return 3;
      K_BR: return 4;
      K_JAL: return 5;
      K_LUI: return 6;
      default: return 0;
    endcase
  endfunction
  // {valid, alu_src, mem_read, mem_write, reg_write, mem_to_reg, muldiv, alu_op, rd}
  function automatic logic [13:0] bundle(input ins_t i);
    logic [1:0] aop;
    aop = (i.k == K_R || i.k == K_M) ? 2'b10 : i.k == K_OPI ? 2'b11 : i.k == K_BR ? 2'b01 : 2'b00;
    return {1'b1, i.k inside {K_LD, K_OPI, K_ST, K_LUI}, i.k == K_LD, i.k == K_ST, writes(i.k),
            i.k == K_LD, i.k == K_M, aop, writes(i.k) ? i.rd : 5'd0};
  endfunction

  task automatic step(input ins_t i, input bit v, input bit beq, output bit adv);
    bit busy, ex_w, haz;
    logic [4:0] erd;
    int epc;
    @(negedge clk);
    inst = enc(i); id_valid = v; br_eq = beq;
    #1;
    busy = busy_left > 0;
    ex_w = ex_v && writes(ex_i.k);
    erd = ex_w ? ex_i.rd : 5'd0;
    haz = v && ((ex_v && ex_i.k == K_LD && reads(i, erd)) ||
                ((i.k == K_BR || i.k == K_JALR) && ((ex_w && reads(i, erd)) || (mem_ld && reads(i, mem_rd)))));
    adv = v && !busy && !haz;
    epc = !adv ? 0 : i.k == K_JALR ? 2 : (i.k == K_JAL || (i.k == K_BR && (beq ^ i.f))) ? 1 : 0;
    chk("stall", int'(stall), int'(busy || haz));
    chk("pc_src", int'(pc_src), epc);
    chk("if_flush", int'(if_flush), int'(epc != 0));
    chk("ex_busy", int'(ex_busy), int'(busy));
    chk("imm_sel", int'(id_imm_sel), imm_of(i.k));
    mem_ld = ex_v && ex_i.k == K_LD;
    mem_rd = erd;
    if (busy) busy_left--;
    else begin
      ex_v = adv && legal(i.k);
      ex_i = i;
      busy_left = (ex_v && i.k == K_M) ? LAT - 1 : 0;
      if (adv) sb.push_back(legal(i.k) ? {bundle(i), 1'b0} : 15'h0001);
    end
  endtask

  task automatic issue(input ins_t i, input bit beq);
    bit a = 1'b0;
    int n = 0;
    while (!a && n < 40) begin step(i, 1'b1, beq, a); n++; end
    if (!a) begin
      errors++;
      $display("FAIL issue_timeout kind %0d never advanced", i.k);
    end
  endtask

  // monitor: a fresh ID/EX entry appears on every edge not preceded by a busy hold
  always @(posedge clk) begin
    logic [14:0] act, e;
    #1;
    act = {ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_muldiv, ex_alu_op, ex_rd, illegal_inst};
    if (!rst_n) prev_busy = 1'b0;
    else begin
      if ((ex_valid || illegal_inst) && !prev_busy) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty got %0h want no output", act);
        end else begin
          e = sb.pop_front();
          chk("ex_bundle", int'(act), int'(e));
        end
      end else if (!ex_valid) chk("bubble", int'(act[14:1]), 0);
      prev_busy = ex_busy;
    end
  end

  initial begin
    bit a;
    ins_t r;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ex", int'({ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_muldiv, ex_alu_op, ex_rd, illegal_inst}), 0);
    chk("rst_comb", int'({stall, if_flush, pc_src, ex_busy}), 0);
    issue(mk(K_M, 8, 1, 2, 0), 1'b0);
    @(posedge clk); #2;
    chk("nom_illegal", int'(u_illegal), 1);
    chk("nom_bubble", int'({u_ex_valid, u_ex_muldiv, u_ex_reg_write, u_ex_rd}), 0);
    chk("nom_stall", int'(u_stall), 0);
    issue(mk(K_R, 3, 1, 2, 0), 1'b0);
    issue(mk(K_LD, 5, 1, 0, 0), 1'b0);
    issue(mk(K_R, 6, 5, 2, 0), 1'b0);
    issue(mk(K_LD, 0, 1, 0, 0), 1'b0);
    issue(mk(K_R, 6, 0, 2, 0), 1'b0);
    issue(mk(K_BR, 0, 1, 2, 0), 1'b1);
    issue(mk(K_BR, 0, 1, 2, 1), 1'b1);
    issue(mk(K_JALR, 1, 2, 0, 0), 1'b0);
    issue(mk(K_LD, 7, 1, 0, 0), 1'b0);
    issue(mk(K_BR, 0, 7, 0, 0), 1'b1);
    issue(mk(K_OPI, 4, 1, 0, 0), 1'b0);
    issue(mk(K_BR, 0, 4, 2, 1), 1'b0);
    issue(mk(K_M, 8, 1, 2, 0), 1'b0);
    issue(mk(K_M, 9, 8, 2, 0), 1'b0);
    issue(mk(K_BR, 0, 9, 0, 0), 1'b1);
    issue(mk(K_BADBR, 0, 1, 2, 0), 1'b0);
    for (int n = 0; n < 500; n++) begin
      r = mk($urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) step(r, 1'b0, 1'($urandom_range(0, 1)), a);
      else issue(r, 1'($urandom_range(0, 1)));
    end
    issue(mk(K_M, 10, 1, 2, 0), 1'b0);
    step(mk(K_R, 1, 1, 1, 0), 1'b0, 1'b0, a);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mop_busy", int'(ex_busy), 0);
    chk("rst_mop_stall", int'(stall), 0);
    chk("rst_mop_ex", int'({ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_muldiv, ex_alu_op, ex_rd}), 0);
    ex_v = 1'b0; busy_left = 0; mem_ld = 1'b0; mem_rd = 5'd0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(mk(K_R, 3, 1, 2, 0), 1'b0);
    issue(mk(K_LUI, 2, 0, 0, 0), 1'b0);
    repeat (3) step(mk(K_R, 1, 1, 1, 0), 1'b0, 1'b0, a);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
